// File: rtl/lsu_pkg.sv
// Shared funct3 codes and state encoding for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/replication, load extraction and
// the misaligned-or-illegal flag for one access description.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_wdata,
  output logic [31:0] ext_rdata,
  output logic        bad
);

  logic [31:0] shifted;
  logic [15:0] half_sel;

  assign shifted  = rdata >> {addr_lo, 3'b000};
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    wstrb      = 4'b0000;
    lane_wdata = wdata;
    ext_rdata  = 32'h0;
    bad        = 1'b0;
    unique case (funct3)
      F3_B: begin
        wstrb      = we ? (4'b0001 << addr_lo) : 4'b0000;
        lane_wdata = {4{wdata[7:0]}};
        ext_rdata  = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        bad        = addr_lo[0];
        wstrb      = we ? (4'b0011 << addr_lo) : 4'b0000;
        lane_wdata = {2{wdata[15:0]}};
        ext_rdata  = {{16{half_sel[15]}}, half_sel};
      end
      F3_W: begin
        bad        = (addr_lo != 2'b00);
        wstrb      = we ? 4'b1111 : 4'b0000;
        ext_rdata  = rdata;
      end
      // Unsigned forms exist only for loads.
      F3_BU: begin
        bad        = we;
        ext_rdata  = {24'h0, shifted[7:0]};
      end
      F3_HU: begin
        bad        = we | addr_lo[0];
        ext_rdata  = {16'h0, half_sel};
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per request over a req/gnt/rvalid bus.
// Optional abort-on-timeout is built only when LSU_TIMEOUT_EN is defined.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err_misalign,
  output logic        err_bus,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        err_mis_q, err_mis_d;
  logic        timeout_hit;

  logic        idle;
  logic        al_we;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_bad;

  // In IDLE the lane logic judges the incoming request; afterwards it works
  // on the captured request to extract the returning load data.
  assign idle       = (state_q == ST_IDLE);
  assign al_we      = idle ? req_we     : we_q;
  assign al_funct3  = idle ? req_funct3 : funct3_q;
  assign al_addr_lo = idle ? req_addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .we         (al_we),
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .wstrb      (al_wstrb),
    .lane_wdata (al_wdata),
    .ext_rdata  (al_rdata),
    .bad        (al_bad)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    err_mis_d   = err_mis_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          funct3_d  = req_funct3;
          addr_d    = req_addr;
          err_mis_d = al_bad;
          if (al_bad) begin
            state_d     = ST_DONE;
            load_data_d = 32'h0;
          end else begin
            state_d = ST_REQ;
            wstrb_d = al_wstrb;
            wdata_d = al_wdata;
          end
        end
      end
      ST_REQ: begin
        if (timeout_hit) begin
          state_d     = ST_DONE;
          load_data_d = 32'h0;
        end else if (mem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d = ST_DONE;
          if (!we_q) load_data_d = al_rdata;
        end else if (timeout_hit) begin
          state_d     = ST_DONE;
          load_data_d = 32'h0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wstrb_q     <= 4'b0000;
      wdata_q     <= 32'h0;
      load_data_q <= 32'h0;
      err_mis_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      err_mis_q   <= err_mis_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_bus_q, err_bus_d;
  logic             active;

  assign active      = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign timeout_hit = active && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // A response arriving on the expiry cycle wins over the abort.
  always_comb begin
    cnt_d     = cnt_q;
    err_bus_d = err_bus_q;
    if (idle) begin
      cnt_d     = '0;
      err_bus_d = 1'b0;
    end else if (active) begin
      cnt_d     = cnt_q + 1'b1;
      err_bus_d = timeout_hit && !((state_q == ST_WAIT) && mem_rvalid);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      err_bus_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      err_bus_q <= err_bus_d;
    end
  end

  assign err_bus = (state_q == ST_DONE) && err_bus_q;
`else
  assign timeout_hit = 1'b0;
  assign err_bus     = 1'b0;
`endif

  assign busy         = !idle;
  assign done         = (state_q == ST_DONE);
  assign err_misalign = done && err_mis_q;
  assign load_data    = load_data_q;
  assign mem_req      = (state_q == ST_REQ);
  assign mem_we       = we_q;
  assign mem_addr     = {addr_q[31:2], 2'b00};
  assign mem_wstrb    = wstrb_q;
  assign mem_wdata    = wdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: per-cycle expectation queue built from
// the access rules, one negedge compare process, plus literal spot checks.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        busy, done, err_misalign, err_bus;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(10), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .load_data(load_data),
    .err_misalign(err_misalign), .err_bus(err_bus),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        mem_req;
    logic        err_mis;
    logic        err_bus;
    logic        chk_bus;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic        chk_wd;
    logic [31:0] mem_wdata;
    logic        chk_ld;
    logic [31:0] load_data;
  } cyc_t;

  localparam int W = $bits(cyc_t);
  logic [W-1:0] exp_q[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          chk_en = 0;
  logic [31:0] ld_hold = 32'h0;
  bit          ld_known = 1;
  int          last_done_cyc = -1;
  int          acc_cyc = 0;
  int          req_cycles = 0;
  logic [31:0] last_ld = 32'h0;
  logic        last_err_mis = 1'b0;
  logic        last_err_bus = 1'b0;
  logic        first_we = 1'b0;
  logic [31:0] first_addr = 32'h0;
  logic [3:0]  first_wstrb = 4'h0;
  logic [31:0] first_wdata = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cyc_t base(input logic bsy);
    cyc_t e;
    e = '0;
    e.busy      = bsy;
    e.chk_ld    = ld_known;
    e.load_data = ld_hold;
    return e;
  endfunction

  task automatic push(input cyc_t e);
    exp_q.push_back(W'(e));
  endtask

  always @(negedge clk) begin : cmp
    cyc_t e;
    if (chk_en) begin
      if (exp_q.size() != 0) e = cyc_t'(exp_q.pop_front());
      else e = base(1'b0);
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("mem_req", 32'(mem_req), 32'(e.mem_req));
      chk("err_misalign", 32'(err_misalign), 32'(e.err_mis));
      chk("err_bus", 32'(err_bus), 32'(e.err_bus));
      if (e.chk_bus) begin
        chk("mem_we", 32'(mem_we), 32'(e.mem_we));
        chk("mem_addr", mem_addr, e.mem_addr);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e.mem_wstrb));
        if (e.chk_wd) chk("mem_wdata", mem_wdata, e.mem_wdata);
      end
      if (e.chk_ld) chk("load_data", load_data, e.load_data);
      if (done) begin
        last_done_cyc = cyc;
        last_ld       = load_data;
        last_err_mis  = err_misalign;
        last_err_bus  = err_bus;
      end
      if (mem_req) begin
        if (req_cycles == 0) begin
          first_we    = mem_we;
          first_addr  = mem_addr;
          first_wstrb = mem_wstrb;
          first_wdata = mem_wdata;
        end
        req_cycles++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_req();
    req_valid  = 1'b1;
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // One complete access: model predicts every cycle, then the bus is played.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int g, input int r, input bit noise);
    bit          legal, mis, bad;
    int          a;
    logic [31:0] exp_ld, exp_wd;
    logic [3:0]  exp_st;
    cyc_t        e;
    a     = int'(addr[1:0]);
    legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis   = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && a != 0);
    bad   = !legal || mis;
    if (f3[1:0] == 2'd0)      exp_ld = (rdata >> (8 * a)) & 32'hFF;
    else if (f3[1:0] == 2'd1) exp_ld = (rdata >> (8 * a)) & 32'hFFFF;
    else                      exp_ld = rdata;
    if (f3 == 3'd0 && exp_ld >= 32'h80)   exp_ld = exp_ld - 32'h100;
    if (f3 == 3'd1 && exp_ld >= 32'h8000) exp_ld = exp_ld - 32'h10000;
    if (!we)            exp_st = 4'h0;
    else if (f3 == 3'd0) exp_st = 4'(1 << a);
    else if (f3 == 3'd1) exp_st = 4'(3 << a);
    else                 exp_st = 4'hF;
    if (f3 == 3'd0)      exp_wd = wdata[7:0] * 32'h01010101;
    else if (f3 == 3'd1) exp_wd = wdata[15:0] * 32'h00010001;
    else                 exp_wd = wdata;

    last_done_cyc = -1;
    req_cycles    = 0;
    push(base(1'b0));
    if (bad) begin
      e = base(1'b1);
      e.done = 1'b1;
      e.err_mis = 1'b1;
      e.chk_ld = 1'b0;
      push(e);
      ld_known = 0;
    end else begin
      for (int i = 0; i <= g; i++) begin
        e = base(1'b1);
        e.mem_req   = 1'b1;
        e.chk_bus   = 1'b1;
        e.mem_we    = we;
        e.mem_addr  = addr & ~32'h3;
        e.mem_wstrb = exp_st;
        e.chk_wd    = we;
        e.mem_wdata = exp_wd;
        push(e);
      end
      for (int i = 0; i <= r; i++) push(base(1'b1));
      e = base(1'b1);
      e.done = 1'b1;
      if (!we) begin
        e.chk_ld    = 1'b1;
        e.load_data = exp_ld;
        ld_hold     = exp_ld;
        ld_known    = 1;
      end
      push(e);
    end

    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    acc_cyc = cyc;
    step();
    if (noise) junk_req(); else req_valid = 1'b0;
    if (!bad) begin
      for (int i = 0; i < g; i++) begin
        mem_gnt = 1'b0; mem_rvalid = noise; mem_rdata = $urandom;
        step();
      end
      mem_gnt = 1'b1; mem_rvalid = noise; mem_rdata = $urandom;
      step();
      mem_gnt = 1'b0;
      for (int i = 0; i < r; i++) begin
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        step();
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      step();
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_err_misalign", 32'(err_misalign), 32'h0);
    chk("rst_err_bus", 32'(err_bus), 32'h0);
    chk_en = 1;
    step();

    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    chk("lw_latency", 32'(last_done_cyc - acc_cyc), 32'd3);
    chk("lw_data", last_ld, 32'hDEADBEEF);
    chk("lw_addr", first_addr, 32'h100);
    chk("lw_wstrb", 32'(first_wstrb), 32'h0);

    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 0);
    chk("lb_data", last_ld, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1);
    chk("lbu_data", last_ld, 32'h00000080);

    access(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h5555AAAA, 0, 1, 0);
    chk("sh_wstrb", 32'(first_wstrb), 32'hC);
    chk("sh_wdata", first_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(first_we), 32'h1);
    chk("sh_latency", 32'(last_done_cyc - acc_cyc), 32'd4);

    access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 0);
    chk("mis_latency", 32'(last_done_cyc - acc_cyc), 32'd1);
    chk("mis_err", 32'(last_err_mis), 32'h1);
    chk("mis_no_req", 32'(req_cycles), 32'd0);

    access(1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, 5, 3, 1);
    chk("slow_req_cycles", 32'(req_cycles), 32'd6);
    chk("slow_latency", 32'(last_done_cyc - acc_cyc), 32'd11);
    chk("slow_data", last_ld, 32'h12345678);

    access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 0, 0, 0);
    chk("lh_data", last_ld, 32'hFFFF8001);
    access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80017FFF, 1, 0, 0);
    chk("lhu_data", last_ld, 32'h00008001);
    access(1'b0, 3'b001, 32'h100, 32'h0, 32'h80017FFF, 0, 2, 1);
    chk("lh_low_data", last_ld, 32'h00007FFF);
    access(1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 0, 0);
    chk("lb_pos_data", last_ld, 32'h0000007F);
    access(1'b1, 3'b000, 32'h201, 32'h1234565A, 32'h0, 1, 0, 1);
    chk("sb_wstrb", 32'(first_wstrb), 32'h2);
    chk("sb_wdata", first_wdata, 32'h5A5A5A5A);
    access(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 2, 2, 0);
    chk("sw_wstrb", 32'(first_wstrb), 32'hF);
    access(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    chk("ill_load_err", 32'(last_err_mis), 32'h1);
    access(1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 0, 0, 1);
    chk("ill_store_err", 32'(last_err_mis), 32'h1);
    access(1'b1, 3'b011, 32'h8, 32'h0, 32'h0, 0, 0, 0);
    access(1'b1, 3'b001, 32'h203, 32'h0, 32'h0, 0, 0, 0);
    chk("sh_mis_err", 32'(last_err_mis), 32'h1);
    access(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 0);
    access(1'b0, 3'b010, 32'h3FC, 32'h0, 32'h0BADF00D, 0, 0, 0);

    // Reset while waiting for a response that arrives on the reset cycle.
    begin
      cyc_t e;
      last_done_cyc = -1;
      push(base(1'b0));
      e = base(1'b1);
      e.mem_req = 1'b1; e.chk_bus = 1'b1; e.mem_we = 1'b0;
      e.mem_addr = 32'h400; e.mem_wstrb = 4'h0;
      push(e);
      push(base(1'b1));
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
      step();
      req_valid = 1'b0; mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; rst_n = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
      step();
      rst_n = 1'b1; mem_rvalid = 1'b0;
      ld_hold = 32'h0; ld_known = 1;
      repeat (3) step();
      chk("rst_mid_no_done", 32'(last_done_cyc), 32'hFFFFFFFF);
      chk("rst_mid_mem_addr", mem_addr, 32'h0);
    end

    access(1'b0, 3'b010, 32'h500, 32'h0, 32'hA5A5A5A5, 0, 0, 0);
    chk("post_rst_data", last_ld, 32'hA5A5A5A5);

`ifdef LSU_TIMEOUT_EN
    begin
      cyc_t e;
      last_done_cyc = -1;
      push(base(1'b0));
      e = base(1'b1);
      e.mem_req = 1'b1; e.chk_bus = 1'b1; e.mem_we = 1'b0;
      e.mem_addr = 32'h600; e.mem_wstrb = 4'h0;
      push(e);
      for (int i = 0; i < 9; i++) push(base(1'b1));
      e = base(1'b1);
      e.done = 1'b1; e.err_bus = 1'b1; e.chk_ld = 1'b1; e.load_data = 32'h0;
      push(e);
      ld_hold = 32'h0; ld_known = 1;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h600;
      acc_cyc = cyc;
      step();
      req_valid = 1'b0; mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      repeat (12) step();
      chk("to_latency", 32'(last_done_cyc - acc_cyc), 32'd11);
      chk("to_err_bus", 32'(last_err_bus), 32'h1);
      chk("to_data", last_ld, 32'h0);
    end
`endif

    repeat (2) step();
    chk_en = 0;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
